cloud_activity_monitor: RTL
===========================

// Module: cloud_activity_monitor
// PURPOSE
//  Downstream of a logic_cloud block: consumes its out_signal (the led/final_signal net) and measures switching activity.
//  Counts toggles of the input over a fixed window of clock cycles. Reports the count and flags a stuck (non-toggling) cloud.
//  Drives a heartbeat LED so the result of a placement experiment can be checked on the board without a debugger.
// PARAMETERS
//  WINDOW_CYCLES  1000000  cycles per measurement window; legal range >= 2
//  CNT_W          24       width of toggle accumulator and toggle_count
// PORTS
//  clk           in   1      single system clock; all logic on posedge
//  rst           in   1      asynchronous, active-high reset
//  in_signal     in   1      monitored net; registered in the clk domain upstream, so it is not synchronised here
//  enable        in   1      level; 1 = run back-to-back windows, 0 = idle
//  toggle_count  out  CNT_W  toggles counted in last completed window, saturating
//  count_valid   out  1      one-cycle pulse when toggle_count updates
//  stuck         out  1      last completed window had zero toggles
//  busy          out  1      1 while state is MEASURE or REPORT
//  led           out  1      heartbeat output
// BEHAVIOUR
//  Reset (async, any time, incl. mid-window):
//   - state=IDLE; prev_r, acc, win_cnt, toggle_count, count_valid, stuck, led, busy all 0
//  prev_r <= in_signal every cycle in every state, so no spurious toggle at window start.
//   - toggle = in_signal ^ prev_r
//  FSM states: IDLE, MEASURE, REPORT.
//   - IDLE:
//     - enable=1 -> MEASURE next cycle; load win_cnt=WINDOW_CYCLES, clear acc
//     - the first cycle after reset is always IDLE
//   - MEASURE:
//     - each cycle: acc <= sat(acc + toggle); win_cnt decrements
//     - acc saturates at 2^CNT_W-1 and never wraps
//     - lasts exactly WINDOW_CYCLES cycles; the toggle seen on the last cycle (win_cnt==1) is counted
//     - on the last cycle -> REPORT
//     - enable=0 in any MEASURE cycle, including the last -> IDLE next cycle
//       - abort: acc discarded, no count_valid
//       - toggle_count, stuck and led hold their previous values
//   - REPORT (exactly 1 cycle):
//     - toggle_count, stuck and count_valid are registered on the MEASURE->REPORT edge, so they are visible during REPORT
//     - count_valid is 1 for this cycle only
//     - stuck = (final acc == 0)
//     - toggles during REPORT are not counted: a documented 1-cycle gap between windows
//     - next state: enable=1 -> MEASURE (acc cleared, win_cnt reloaded); else IDLE
//  Window period with enable held high: WINDOW_CYCLES+1 cycles between count_valid pulses.
//  led is updated only on the MEASURE->REPORT edge:
//   - final acc > 0 -> led inverts
//   - final acc == 0 -> led forced 0
//  busy = (state != IDLE); it is the registered state decode.
//  Window counter width = $clog2(WINDOW_CYCLES+1).
// TESTING  (bench overrides WINDOW_CYCLES=16, CNT_W=8 unless noted)
//  1 Assert rst mid-run, release -> all outputs 0; busy=0 for the first cycle; no count_valid.
//  2 enable=1, in_signal toggles every cycle
//    -> count_valid every 17 cycles, toggle_count=16, stuck=0; led alternates 1,0,1 over successive reports
//  3 enable=1, in_signal held 1 from reset
//    -> toggle_count=0, stuck=1, led=0; no toggle counted at window start
//  4 CNT_W=3, in_signal toggles every cycle
//    -> toggle_count=7 (saturated) with no wrap; stuck=0
//  5 in_signal toggles on cycles 1..5 only (5 toggles), then enable=0 on cycle 10 of the next window
//    -> first report=5; IDLE next cycle; no further count_valid; toggle_count stays 5
//  6 Async rst pulse at cycle 8 of a window with in_signal toggling
//    -> outputs clear immediately; after release plus enable, the next report is exactly 16

Source files
------------

// File: rtl/cloud_activity_monitor_if.sv
// Monitor bus: the observed net and run control in, window results out.
interface cloud_activity_monitor_if #(
    parameter int CNT_W = 24
);
    logic             in_signal;
    logic             enable;
    logic [CNT_W-1:0] toggle_count;
    logic             count_valid;
    logic             stuck;
    logic             busy;
    logic             led;

    modport master (
        output in_signal, enable,
        input  toggle_count, count_valid, stuck, busy, led
    );

    modport slave (
        input  in_signal, enable,
        output toggle_count, count_valid, stuck, busy, led
    );
endinterface

// File: rtl/cloud_activity_monitor.sv
// Counts toggles of a registered net over fixed windows, reports count/stuck and drives a heartbeat LED.
// Report follows the last window cycle by one clock; a 1-cycle REPORT gap separates back-to-back windows.
module cloud_activity_monitor #(
    parameter int WINDOW_CYCLES = 1000000,
    parameter int CNT_W         = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    cloud_activity_monitor_if.slave mon
);
    localparam int WC_W = $clog2(WINDOW_CYCLES + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MEASURE = 2'd1;
    localparam logic [1:0] S_REPORT  = 2'd2;

    localparam logic [CNT_W-1:0] ACC_MAX  = '1;
    localparam logic [WC_W-1:0]  WIN_LOAD = WC_W'(WINDOW_CYCLES);

    logic [1:0]       state;
    logic             prev_r;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] acc_nxt;
    logic [WC_W-1:0]  win_cnt;
    logic             toggle;
    logic             last_cycle;

    logic [CNT_W-1:0] toggle_count_r;
    logic             count_valid_r;
    logic             stuck_r;
    logic             led_r;

    assign toggle     = mon.in_signal ^ prev_r;
    assign last_cycle = (win_cnt == WC_W'(1));

    // Saturating accumulate: holds at all-ones instead of wrapping.
    always_comb begin
        acc_nxt = acc;
        if (toggle && (acc != ACC_MAX)) begin
            acc_nxt = acc + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            prev_r         <= 1'b0;
            acc            <= '0;
            win_cnt        <= '0;
            toggle_count_r <= '0;
            count_valid_r  <= 1'b0;
            stuck_r        <= 1'b0;
            led_r          <= 1'b0;
        end else begin
            prev_r        <= mon.in_signal;
            count_valid_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mon.enable) begin
                        state   <= S_MEASURE;
                        win_cnt <= WIN_LOAD;
                        acc     <= '0;
                    end
                end
                S_MEASURE: begin
                    if (!mon.enable) begin
                        // Abort drops the partial window; published results are left untouched.
                        state <= S_IDLE;
                    end else begin
                        acc     <= acc_nxt;
                        win_cnt <= win_cnt - WC_W'(1);
                        if (last_cycle) begin
                            state          <= S_REPORT;
                            toggle_count_r <= acc_nxt;
                            count_valid_r  <= 1'b1;
                            stuck_r        <= (acc_nxt == '0);
                            led_r          <= (acc_nxt == '0) ? 1'b0 : ~led_r;
                        end
                    end
                end
                S_REPORT: begin
                    if (mon.enable) begin
                        state   <= S_MEASURE;
                        win_cnt <= WIN_LOAD;
                        acc     <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mon.toggle_count = toggle_count_r;
    assign mon.count_valid  = count_valid_r;
    assign mon.stuck        = stuck_r;
    assign mon.led          = led_r;
    assign mon.busy         = (state != S_IDLE);
endmodule
